// File: rtl/rsa_modexp_engine_if.sv
// Request/response bundle for the modular-exponentiation engine.
// The requester drives operands and start; the engine answers with status and result.
interface rsa_modexp_engine_if #(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     base;
    logic [EXP_WIDTH-1:0] exponent;
    logic [WIDTH-1:0]     modulus;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [WIDTH-1:0]     result;

    modport master (
        output start, base, exponent, modulus,
        input  busy, done, err, result
    );

    modport slave (
        input  start, base, exponent, modulus,
        output busy, done, err, result
    );
endinterface

// File: rtl/rsa_modexp_engine.sv
// Constant-time left-to-right square-and-multiply: result = base^exponent mod modulus.
// Every exponent bit costs one SQUARE and one MULT cycle regardless of its value.
module rsa_modexp_engine #(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    rsa_modexp_engine_if.slave bus
);

    localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(EXP_WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        SQUARE,
        MULT,
        FINISH
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     base_r;
    logic [WIDTH-1:0]     mod_r;
    logic [EXP_WIDTH-1:0] exp_r;
    logic [IDX_W-1:0]     idx;
    logic [WIDTH-1:0]     result_r;
    logic                 done_r;
    logic                 err_r;

    logic                 busy_c;
    logic [WIDTH-1:0]     mod_safe;
    logic [WIDTH-1:0]     base_red;
    logic [WIDTH-1:0]     mul_b;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   mod_ext;
    logic [WIDTH-1:0]     acc_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.modulus == '0) state_nxt = FINISH;
                    else                   state_nxt = SQUARE;
                end
            end
            SQUARE:  state_nxt = MULT;
            MULT:    state_nxt = (idx == '0) ? IDLE : SQUARE;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status and reduction datapath; divisors are forced nonzero so no divide-by-zero exists
    always_comb begin
        busy_c   = (state != IDLE);
        mod_safe = (bus.modulus == '0) ? ONE : bus.modulus;
        base_red = bus.base % mod_safe;
        if (state == SQUARE)  mul_b = acc;
        else if (exp_r[idx]) mul_b = base_r;
        else                  mul_b = ONE;
        prod    = (2*WIDTH)'(acc) * (2*WIDTH)'(mul_b);
        mod_ext = (mod_r == '0) ? (2*WIDTH)'(1) : (2*WIDTH)'(mod_r);
        acc_nxt = WIDTH'(prod % mod_ext);
    end

    // Operand capture, accumulator steps and completion pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            base_r   <= '0;
            mod_r    <= '0;
            exp_r    <= '0;
            idx      <= '0;
            result_r <= '0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && bus.modulus != '0) begin
                        mod_r  <= bus.modulus;
                        exp_r  <= bus.exponent;
                        base_r <= base_red;
                        acc    <= (bus.modulus == ONE) ? '0 : ONE;
                        idx    <= IDX_LAST;
                    end
                end
                SQUARE: acc <= acc_nxt;
                MULT: begin
                    acc <= acc_nxt;
                    if (idx == '0) begin
                        result_r <= acc_nxt;
                        done_r   <= 1'b1;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                FINISH: begin
                    result_r <= '0;
                    done_r   <= 1'b1;
                    err_r    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = busy_c;
    assign bus.done   = done_r;
    assign bus.err    = err_r;
    assign bus.result = result_r;

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Directed bench for rsa_modexp_engine with hand-computed vectors.
// Outputs are sampled 1 time unit after each rising edge.
module tb_rsa_modexp_engine;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rsa_modexp_engine_if #(.WIDTH(16), .EXP_WIDTH(8)) bus ();

    rsa_modexp_engine #(.WIDTH(16), .EXP_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] b, input logic [7:0] e,
                          input logic [15:0] m, output int res,
                          output int lat, output int bcnt, output int eat);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.base     = b;
        bus.exponent = e;
        bus.modulus  = m;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat  = -1;
        res  = -1;
        eat  = -1;
        bcnt = 0;
        if (bus.busy) bcnt++;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = i;
                res = int'(bus.result);
                eat = int'(bus.err);
                break;
            end
            if (bus.busy) bcnt++;
        end
    endtask

    int res, lat, bcnt, eat, lat1, lat2, ndone, first;

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.base     = '0;
        bus.exponent = '0;
        bus.modulus  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_err", int'(bus.err), 0);
        check("rst_result", int'(bus.result), 0);
        rst = 1'b0;

        // Encrypt 4^7 mod 33
        run_op(16'd4, 8'd7, 16'd33, res, lat, bcnt, eat);
        check("enc_result", res, 16);
        check("enc_latency", lat, 16);
        check("enc_err", eat, 0);
        check("enc_busy_cycles", bcnt, 16);
        @(posedge clk);
        #1;
        check("enc_done_pulse", int'(bus.done), 0);
        check("enc_result_held", int'(bus.result), 16);

        // Decrypt 16^3 mod 33
        run_op(16'd16, 8'd3, 16'd33, res, lat, bcnt, eat);
        check("dec_result", res, 4);

        // Base above modulus: 40^7 mod 33
        run_op(16'd40, 8'd7, 16'd33, res, lat, bcnt, eat);
        check("prered_result", res, 28);

        // 2^10 mod 1000
        run_op(16'd2, 8'd10, 16'd1000, res, lat, bcnt, eat);
        check("wide_result", res, 24);
        check("wide_latency", lat, 16);

        // Exponent pattern must not change latency
        run_op(16'd5, 8'h01, 16'd33, res, lat1, bcnt, eat);
        check("exp01_result", res, 5);
        run_op(16'd2, 8'hFF, 16'd33, res, lat2, bcnt, eat);
        check("expFF_result", res, 32);
        check("exp01_latency", lat1, 16);
        check("expFF_latency", lat2, 16);

        // Zero exponent
        run_op(16'd9, 8'd0, 16'd33, res, lat, bcnt, eat);
        check("exp0_result", res, 1);

        // Zero modulus
        run_op(16'd9, 8'd7, 16'd0, res, lat, bcnt, eat);
        check("mod0_latency", lat, 1);
        check("mod0_err", eat, 1);
        check("mod0_result", res, 0);
        @(posedge clk);
        #1;
        check("mod0_done_low", int'(bus.done), 0);
        check("mod0_err_low", int'(bus.err), 0);

        // Unit modulus
        run_op(16'd77, 8'd7, 16'd1, res, lat, bcnt, eat);
        check("mod1_result", res, 0);
        check("mod1_err", eat, 0);

        // start while busy is ignored
        @(negedge clk);
        bus.start    = 1'b1;
        bus.base     = 16'd4;
        bus.exponent = 8'd7;
        bus.modulus  = 16'd33;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone = 0;
        first = -1;
        res   = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                ndone++;
                if (first < 0) begin
                    first = i;
                    res   = int'(bus.result);
                end
            end
            bus.start = 1'b0;
            if (i == 4) begin
                bus.start    = 1'b1;
                bus.base     = 16'd2;
                bus.exponent = 8'd10;
                bus.modulus  = 16'd1000;
            end
        end
        check("busy_start_ndone", ndone, 1);
        check("busy_start_latency", first, 16);
        check("busy_start_result", res, 16);

        // Start on the done cycle
        run_op(16'd4, 8'd7, 16'd33, res, lat, bcnt, eat);
        check("b2b_first_result", res, 16);
        bus.start    = 1'b1;
        bus.base     = 16'd16;
        bus.exponent = 8'd3;
        bus.modulus  = 16'd33;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = -1;
        res = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = i + 1;
                res = int'(bus.result);
                break;
            end
        end
        check("b2b_gap", lat, 17);
        check("b2b_second_result", res, 4);

        // Reset mid-operation
        @(negedge clk);
        bus.start    = 1'b1;
        bus.base     = 16'd4;
        bus.exponent = 8'd7;
        bus.modulus  = 16'd33;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_result", int'(bus.result), 0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        run_op(16'd40, 8'd7, 16'd33, res, lat, bcnt, eat);
        check("post_rst_result", res, 28);
        check("post_rst_latency", lat, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rsa_modexp_engine.md
Name: rsa_modexp_engine

Overview:
- Parameterised modular-exponentiation core: result = base^exponent mod modulus.
- Next generation of the fixed-key encryption/decryption blocks in the RSA datapath. It replaces hard-wired e=7/d=3, n=33 and the 64-bit unreduced product with runtime exponent/modulus and per-step reduction.
- Constant-time: runtime depends only on EXP_WIDTH, never on key bits.
- Sits between the plaintext RAM read port and the ciphertext RAM write port. Encrypt vs decrypt is chosen purely by the exponent supplied.

Parameters:
- WIDTH, 16, bit width of base, modulus, result.
- EXP_WIDTH, 8, bit width of exponent; sets latency.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request pulse; sampled only when busy=0
- base  input  WIDTH  message/ciphertext value, captured on accepted start
- exponent  input  EXP_WIDTH  key exponent (e or d), captured on accepted start
- modulus  input  WIDTH  modulus n, captured on accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle pulse with done when modulus==0
- result  output  WIDTH  final value; held until the next completion

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (synchronous, any state, including mid-operation): state=IDLE; busy=0, done=0, err=0, result=0. Internal acc, base_r, exp_r, mod_r and idx are cleared. No completion pulse is produced for an aborted operation.
- States: IDLE, SQUARE, MULT, FINISH.
- IDLE: on start=1, capture on that edge:
  - mod_r=modulus, exp_r=exponent
  - base_r = base mod modulus (base>=modulus is legal)
  - acc = (modulus==1) ? 0 : 1
  - idx = EXP_WIDTH-1; busy<=1; go to SQUARE
- If modulus==0 at start: capture nothing and go to FINISH with err pending. Do not divide by zero.
- SQUARE (1 cycle): acc <= (acc*acc) mod mod_r. The product is 2*WIDTH bits, full precision, no truncation before the reduction. Go to MULT.
- MULT (1 cycle): acc <= (acc * (exp_r[idx] ? base_r : 1)) mod mod_r. The multiply is always performed, so timing and power are independent of the key bit.
  - If idx==0: result <= new acc, done<=1, busy<=0, go to IDLE.
  - Else: idx<=idx-1, go to SQUARE.
- FINISH (modulus==0 path only): result<=0, done<=1, err<=1, busy<=0, go to IDLE. Latency is 1 cycle.
- Latency: done is high in the cycle after edge N+2*EXP_WIDTH, where edge N accepted start. With the default this is 16 clocks. busy is high over the same interval.
- done and err are single-cycle pulses. result changes only on a done edge.
- start while busy=1: ignored, no queuing. Operand changes while busy have no effect.
- start on the same cycle done is high: busy is already 0, so the request is accepted and back-to-back throughput is one result per 2*EXP_WIDTH+1 cycles.
- exponent==0: every MULT uses 1, so result = 1 mod modulus (1, or 0 if modulus==1).
- All intermediates satisfy acc < mod_r, so no overflow for any WIDTH.

Test Plan:
- Encrypt: modulus=33, exponent=7, base=4, start pulse -> done exactly 16 cycles later, result=16, err=0, busy high for those 16 cycles.
- Decrypt round trip: modulus=33, exponent=3, base=16 -> result=4. Also base=40, exponent=7, modulus=33 (pre-reduction) -> result=28.
- Wider operands: modulus=1000, exponent=10, base=2 -> result=24. Latency still 16 cycles, independent of exponent bit pattern; compare exponent=0x01 vs 0xFF, which must be identical.
- Edge cases:
  - exponent=0, modulus=33 -> result=1.
  - modulus=1, any base -> result=0.
  - modulus=0 -> done and err pulse together 1 cycle after start, result=0.
- Handshake: start re-asserted while busy -> ignored, result unchanged, single done. start on the done cycle -> accepted, second done 17 cycles after the first.
- Reset mid-operation (rst at cycle 5 of 16) -> next cycle busy=0, done=0, result=0. A new start afterwards completes correctly with full latency.
